// File: rtl/hdmi_tx_vpg_pattern.sv
// Video pattern generator: raster timing plus colour bars, grey ramp, checkerboard or solid blue.
// Optional VPG_BORDER_EN macro draws a white one-pixel frame around the active area.
module hdmi_tx_vpg_pattern #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] color_mode,
    output logic       vpg_de,
    output logic       vpg_hs,
    output logic       vpg_vs,
    output logic [7:0] vpg_r,
    output logic [7:0] vpg_g,
    output logic [7:0] vpg_b,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least 8/4 bits wide so the ramp and checker bit selects always exist.
    localparam int HW    = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VW    = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);
`ifdef VPG_BORDER_EN
    localparam logic [HW-1:0]  H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0]  V_ACT_LAST = VW'(V_ACTIVE - 1);
`endif

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d;
    mode_e          mode_q, mode_d;
    logic [BPW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic           de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [23:0]    rgb_q, rgb_d;
    logic           h_wrap, v_last;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        v_last    = (v_cnt_q == V_LAST);
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        mode_d    = mode_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;

        if (h_wrap) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
        if (h_wrap && v_last) begin
            mode_d = mode_e'(color_mode);
        end

        // Bar position tracks h_cnt incrementally; index holds at 7 for remainder pixels.
        if (h_wrap) begin
            bar_pix_d = '0;
            bar_idx_d = '0;
        end else if (bar_idx_q != 3'd7) begin
            if (bar_pix_q == BAR_LAST) begin
                bar_pix_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 1'b1;
            end
        end

        de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_d = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_d = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);

        rgb_d = '0;
        case (mode_q)
            MODE_BARS:  rgb_d = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
            MODE_RAMP:  rgb_d = {3{h_cnt_q[7:0]}};
            MODE_CHECK: rgb_d = {24{h_cnt_q[3] ^ v_cnt_q[3]}};
            MODE_SOLID: rgb_d = 24'h0000FF;
            default:    rgb_d = '0;
        endcase
`ifdef VPG_BORDER_EN
        if (h_cnt_q == '0 || h_cnt_q == H_ACT_LAST || v_cnt_q == '0 || v_cnt_q == V_ACT_LAST) begin
            rgb_d = '1;
        end
`endif
        if (!de_d) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            mode_q    <= MODE_BARS;
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            mode_q    <= mode_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vpg_de      = de_q;
    assign vpg_hs      = hs_q;
    assign vpg_vs      = vs_q;
    assign vpg_r       = rgb_q[23:16];
    assign vpg_g       = rgb_q[15:8];
    assign vpg_b       = rgb_q[7:0];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_tx_vpg_pattern.sv
// Scoreboard bench: a small 16x8 raster DUT and a 300-pixel-wide DUT checked cycle by cycle.
module tb_hdmi_tx_vpg_pattern;

    logic       clk;
    logic       reset_n;
    logic [1:0] color_mode, color_mode2;
    logic       de1, hs1, vs1, fs1, de2, hs2, vs2, fs2;
    logic [7:0] r1, g1, b1, r2, g2, b2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fs = -1;
    int h1, v1, m1, h2, v2, m2;
    logic [27:0] sb1[$];
    logic [27:0] sb2[$];

    hdmi_tx_vpg_pattern #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .color_mode(color_mode),
        .vpg_de(de1), .vpg_hs(hs1), .vpg_vs(vs1),
        .vpg_r(r1), .vpg_g(g1), .vpg_b(b1), .frame_start(fs1)
    );

    hdmi_tx_vpg_pattern #(
        .H_ACTIVE(300), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .color_mode(color_mode2),
        .vpg_de(de2), .vpg_hs(hs2), .vpg_vs(vs2),
        .vpg_r(r2), .vpg_g(g2), .vpg_b(b2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Returns {frame_start, de, hs, vs, rgb} for pixel (h, v).
    function automatic logic [27:0] model(int h, int v, int m, int ha, int hf, int hsw,
                                          int va, int vf, int vsw);
        logic de, hs, vs, fs;
        logic [23:0] rgb;
        int idx;
        logic [7:0] g;
        de = (h < ha) && (v < va);
        hs = (h >= ha + hf) && (h < ha + hf + hsw);
        vs = (v >= va + vf) && (v < va + vf + vsw);
        fs = (h == 0) && (v == 0);
        case (m)
            0: begin
                idx = h / (ha / 8);
                if (idx > 7) idx = 7;
                rgb = bar_colour(idx);
            end
            1: begin
                g = 8'(h % 256);
                rgb = {g, g, g};
            end
            2: rgb = ((((h / 8) ^ (v / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: rgb = 24'h0000FF;
        endcase
`ifdef VPG_BORDER_EN
        if (h == 0 || h == ha - 1 || v == 0 || v == va - 1) rgb = 24'hFFFFFF;
`endif
        if (!de) rgb = 24'h0;
        return {fs, de, hs, vs, rgb};
    endfunction

    task automatic model_reset();
        h1 = 0; v1 = 0; m1 = 0;
        h2 = 0; v2 = 0; m2 = 0;
        last_fs = -1;
        sb1.delete();
        sb2.delete();
    endtask

    task automatic step();
        logic [27:0] exp1, exp2, got1, got2;
        int ph1, pv1, ph2, pv2;
        sb1.push_back(model(h1, v1, m1, 16, 2, 2, 8, 1, 1));
        sb2.push_back(model(h2, v2, m2, 300, 2, 2, 2, 1, 1));
        ph1 = h1; pv1 = v1; ph2 = h2; pv2 = v2;
        @(posedge clk);
        if (h1 == 23 && v1 == 11) m1 = int'(color_mode);
        if (h1 == 23) begin h1 = 0; v1 = (v1 == 11) ? 0 : v1 + 1; end else h1++;
        if (h2 == 307 && v2 == 4) m2 = int'(color_mode2);
        if (h2 == 307) begin h2 = 0; v2 = (v2 == 4) ? 0 : v2 + 1; end else h2++;
        #1;
        cyc++;
        got1 = {fs1, de1, hs1, vs1, r1, g1, b1};
        got2 = {fs2, de2, hs2, vs2, r2, g2, b2};
        exp1 = sb1.pop_front();
        exp2 = sb2.pop_front();
        total++;
        assert (got1 === exp1) else begin
            bad++;
            $error("FAIL px1 h=%0d v=%0d got=%h exp=%h", ph1, pv1, got1, exp1);
        end
        total++;
        assert (got2 === exp2) else begin
            bad++;
            $error("FAIL px2 h=%0d v=%0d got=%h exp=%h", ph2, pv2, got2, exp2);
        end
        if (fs1 === 1'b1) begin
            if (last_fs >= 0) begin
                total++;
                assert (cyc - last_fs == 288) else begin
                    bad++;
                    $error("FAIL fs_period got=%0d exp=288", cyc - last_fs);
                end
            end
            last_fs = cyc;
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero(string tag);
        logic [27:0] got1, got2;
        got1 = {fs1, de1, hs1, vs1, r1, g1, b1};
        got2 = {fs2, de2, hs2, vs2, r2, g2, b2};
        total++;
        assert (got1 === 28'h0) else begin
            bad++;
            $error("FAIL %s dut1 got=%h exp=0", tag, got1);
        end
        total++;
        assert (got2 === 28'h0) else begin
            bad++;
            $error("FAIL %s dut2 got=%h exp=0", tag, got2);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        color_mode  = 2'd0;
        color_mode2 = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        model_reset();
        reset_n = 1'b1;

        // Frame 1 bars; request checkerboard at line 3, effective from frame 2.
        run(72);
        color_mode = 2'd2;
        run(216);
        // Frame 2 checkerboard; request solid blue for frame 3.
        run(72);
        color_mode = 2'd3;
        run(216);
        run(288);
        // Into frame 4, then reset at line 5 pixel 7.
        run(5 * 24 + 7);
        reset_n = 1'b0;
        #2;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        model_reset();
        reset_n = 1'b1;
        // Post-reset frame is bars, following frame solid; dut2 reaches its ramp frame.
        run(576);
        run(3080 - 576);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_tx_vpg_pattern.md
HDMI_TX_VPG_PATTERN -- requirements
Module: hdmi_tx_vpg_pattern

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 40, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 220, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-006 Parameter V_FP / V_SYNC / V_BP, defaults 5 / 5 / 20, vertical porch and sync widths in lines.
REQ-007 clk  input  1  pixel clock; the block's only clock.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 color_mode  input  2  pattern select, driven by the 2-bit colour PIO out_port on clk.
REQ-010 vpg_de  output  1  data enable, high during active pixels.
REQ-011 vpg_hs / vpg_vs  output  1 each  horizontal / vertical sync, active-high.
REQ-012 vpg_r / vpg_g / vpg_b  output  8 each  pixel colour.
REQ-013 frame_start  output  1  one-cycle pulse marking pixel (0,0).

Function
REQ-014 The block SHALL keep h_cnt in 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; h_cnt SHALL increment every clk and wrap to 0.
REQ-015 The block SHALL keep v_cnt in 0..V_TOTAL-1, incrementing when h_cnt wraps and wrapping to 0 after V_TOTAL-1.
REQ-016 Line order SHALL be active, front porch, sync, back porch; frame order likewise.
REQ-017 de SHALL be (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
REQ-018 hs SHALL be high for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
REQ-019 vs SHALL be high for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-020 All outputs SHALL be registered with one-cycle latency from (h_cnt, v_cnt), so sync, de and RGB stay mutually aligned.
REQ-021 mode_q SHALL load color_mode only on the cycle h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1; a mid-frame change of color_mode SHALL NOT affect the current frame.
REQ-022 mode 0 (colour bars): 8 bars of width H_ACTIVE/8 (integer), generated by a bar-pixel counter without a divider; bar index clamps at 7 for any remainder pixels.
REQ-023 Bar colours in order SHALL be white, yellow, cyan, green, magenta, red, blue, black, using 8'hFF/8'h00 components.
REQ-024 mode 1 (grey ramp): r=g=b=h_cnt[7:0], wrapping modulo 256.
REQ-025 mode 2 (checkerboard): white when h_cnt[3]^v_cnt[3], else black.
REQ-026 mode 3 (solid): r=00, g=00, b=FF.
REQ-027 When de is low, r/g/b SHALL be 0.
REQ-028 frame_start SHALL be high for exactly the output cycle carrying pixel (0,0), once per frame.

Reset
REQ-029 While reset_n is low: h_cnt, v_cnt, mode_q, bar counter and all outputs SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL clear state immediately and asynchronously.
REQ-031 After release, the first output cycle SHALL present pixel (0,0) with mode_q=0 (colour bars) and frame_start=1; the color_mode loaded at the end of this frame SHALL take effect from the second frame.

Configuration
REQ-032 Macro VPG_BORDER_EN defined: active pixels with h_cnt==0, h_cnt==H_ACTIVE-1, v_cnt==0 or v_cnt==V_ACTIVE-1 SHALL output FFFFFF, overriding every mode.
REQ-033 Macro VPG_BORDER_EN undefined: no border logic, and pattern pixels SHALL be unmodified.

Verification (params H 16/2/2/4, V 8/1/1/2: H_TOTAL=24, V_TOTAL=12, frame = 288 cycles)
REQ-034 Reset release, color_mode=0 -> frame_start on the first output cycle; pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000; de high 16 cycles per active line.
REQ-035 Free run 288 cycles -> hs high at output positions 18-19 of each line; vs high for line 9 (24 cycles); de low on lines 8-11; frame_start period 288.
REQ-036 color_mode changed 0->2 at line 3 -> frame unchanged through the end; next frame: pixel (8,0) white, (0,0) black, (0,8) n/a, (8,8) n/a (V_ACTIVE=8); line 0 alternates in 8-pixel blocks.
REQ-037 mode 1 with H_ACTIVE=300 override -> pixel 255 = FFFFFF, pixel 256 = 000000 (wrap); mode 3 -> all active pixels 0000FF, blanking 000000.
REQ-038 reset_n pulsed low at line 5 pixel 7 -> all outputs 0 within the reset window; after release, pixel (0,0) and frame_start, mode_q back to 0.
REQ-039 VPG_BORDER_EN defined, mode 3 -> line 0 and line 7 all FFFFFF; pixels 0 and 15 of lines 1-6 FFFFFF; interior 0000FF.
